irq_pending_arbiter: RTL and testbench

- Front-end stage that collects eight interrupt/request lines into a sticky pending register and applies a per-bit enable mask.
- Presents the highest-priority enabled pending request as a 3-bit index over a valid/ready handshake; bit 7 is highest priority, bit 0 lowest.
- Clears the granted bit on handshake completion.
- Sits between raw request sources and the downstream consumer of encoded request IDs (interrupt dispatch, arbiter grant logic).

---
 rtl/irq_pending_arbiter_pkg.sv | 25 ++
 rtl/irq_pending_arbiter_if.sv | 12 +
 rtl/irq_pending_arbiter_capture.sv | 30 +++
 rtl/irq_pending_arbiter.sv | 120 ++++++++++++
 tb/tb_irq_pending_arbiter.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/irq_pending_arbiter_pkg.sv
// Shared types and helpers for the pending-request arbiter and other
// priority-encoder users.
package irq_pending_arbiter_pkg;

  localparam int IRQ_N_REQ = 8;
  localparam int IRQ_ID_W  = 3;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } irq_state_e;

  // Index of the most significant set bit; 0 when the vector is empty.
  function automatic logic [IRQ_ID_W-1:0] highest_set_bit(input logic [IRQ_N_REQ-1:0] vec);
    logic [IRQ_ID_W-1:0] idx;
    idx = {IRQ_ID_W{1'b0}};
    for (int i = 0; i < IRQ_N_REQ; i++) begin
      if (vec[i]) begin
        idx = IRQ_ID_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_pending_arbiter_if.sv
// Valid/ready handshake carrying the encoded request ID to the consumer.
interface irq_pending_arbiter_if;
  import irq_pending_arbiter_pkg::*;

  logic                out_valid;
  logic [IRQ_ID_W-1:0] out_id;
  logic                out_ready;

  modport master (output out_valid, output out_id, input  out_ready);
  modport slave  (input  out_valid, input  out_id, output out_ready);

endinterface

// File: rtl/irq_pending_arbiter_capture.sv
// Request capture: registers the raw lines once and produces the per-bit
// set vector, rising-edge or level depending on EDGE_MASK.
module irq_capture
  import irq_pending_arbiter_pkg::*;
#(
  parameter logic [IRQ_N_REQ-1:0] EDGE_MASK = 8'hFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IRQ_N_REQ-1:0] req_in,
  output logic [IRQ_N_REQ-1:0] set
);

  logic [IRQ_N_REQ-1:0] req_q;

  // Loading req_in during reset means a line held high across release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= req_in;
    end else begin
      req_q <= req_in;
    end
  end

  // Edge bits fire on 0->1 transitions, level bits fire while high.
  always_comb begin
    set = (req_in & ~req_q & EDGE_MASK) | (req_in & ~EDGE_MASK);
  end

endmodule

// File: rtl/irq_pending_arbiter.sv
// Sticky pending register with per-bit enable, presenting the highest-priority
// enabled request (bit 7 highest) as an ID over a valid/ready handshake.
module irq_pending_arbiter
  import irq_pending_arbiter_pkg::*;
#(
  parameter int                   N_REQ     = IRQ_N_REQ,
  parameter int                   ID_W      = IRQ_ID_W,
  parameter logic [IRQ_N_REQ-1:0] EDGE_MASK = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_in,
  input  logic [N_REQ-1:0]      mask,
  input  logic                  clr_all,
  irq_pending_arbiter_if.master bus,
  output logic [N_REQ-1:0]      pending,
  output logic                  overflow
);

  irq_state_e        state_r;
  irq_state_e        state_nxt_s;
  logic [N_REQ-1:0]  set_s;
  logic [N_REQ-1:0]  clr_s;
  logic [N_REQ-1:0]  eligible_s;
  logic [N_REQ-1:0]  pending_nxt_s;
  logic              overflow_nxt_s;
  logic              valid_nxt_s;
  logic [ID_W-1:0]   id_nxt_s;

  irq_capture #(
    .EDGE_MASK (EDGE_MASK)
  ) u_capture (
    .clk    (clk),
    .rst    (rst),
    .req_in (req_in),
    .set    (set_s)
  );

  // Pending update: set wins over the grant clear, flush overrides both.
  always_comb begin
    clr_s          = {N_REQ{1'b0}};
    eligible_s     = pending & mask;
    pending_nxt_s  = pending;
    overflow_nxt_s = 1'b0;
    if (bus.out_valid && bus.out_ready) begin
      clr_s = {{(N_REQ-1){1'b0}}, 1'b1} << bus.out_id;
    end else begin
      clr_s = {N_REQ{1'b0}};
    end
    if (clr_all) begin
      pending_nxt_s  = {N_REQ{1'b0}};
      overflow_nxt_s = 1'b0;
    end else begin
      pending_nxt_s  = (pending & ~clr_s) | set_s;
      overflow_nxt_s = |(set_s & pending & ~clr_s);
    end
  end

  // Presentation FSM: the ID is latched on entry to PRESENT and never altered there.
  always_comb begin
    state_nxt_s = state_r;
    valid_nxt_s = bus.out_valid;
    id_nxt_s    = bus.out_id;
    if (clr_all) begin
      state_nxt_s = IDLE;
      valid_nxt_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|eligible_s) begin
            state_nxt_s = PRESENT;
            valid_nxt_s = 1'b1;
            id_nxt_s    = highest_set_bit(eligible_s);
          end else begin
            state_nxt_s = IDLE;
            valid_nxt_s = 1'b0;
          end
        end
        PRESENT: begin
          if (bus.out_ready) begin
            state_nxt_s = IDLE;
            valid_nxt_s = 1'b0;
          end else begin
            state_nxt_s = PRESENT;
            valid_nxt_s = 1'b1;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          valid_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered outputs and pending state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending       <= {N_REQ{1'b0}};
      overflow      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_id    <= {ID_W{1'b0}};
    end else begin
      pending       <= pending_nxt_s;
      overflow      <= overflow_nxt_s;
      bus.out_valid <= valid_nxt_s;
      bus.out_id    <= id_nxt_s;
    end
  end

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Directed bench: an edge-mode instance driven from a vector table plus hand
// sequences, and a level-mode instance for the re-pend and reset-release cases.
module tb_irq_pending_arbiter;

  typedef struct {
    logic [7:0] req;
    logic [7:0] msk;
    logic       flush;
    logic       rdy;
    logic [7:0] exp_pend;
    logic       exp_valid;
    logic [2:0] exp_id;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [7:0] req_a, mask_a, pend_a;
  logic [7:0] req_b, mask_b, pend_b;
  logic       clr_a, clr_b, ovf_a, ovf_b;

  int n_checks = 0;
  int n_fail   = 0;

  irq_pending_arbiter_if bus_a ();
  irq_pending_arbiter_if bus_b ();

  irq_pending_arbiter dut_a (
    .clk (clk), .rst (rst_a), .req_in (req_a), .mask (mask_a), .clr_all (clr_a),
    .bus (bus_a), .pending (pend_a), .overflow (ovf_a)
  );

  irq_pending_arbiter #(.EDGE_MASK (8'hFE)) dut_b (
    .clk (clk), .rst (rst_b), .req_in (req_b), .mask (mask_b), .clr_all (clr_b),
    .bus (bus_b), .pending (pend_b), .overflow (ovf_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [7:0] p, input logic v,
                         input logic [2:0] id, input logic o);
    check({tag, " pending"}, pend_a, p);
    check({tag, " valid"}, {7'd0, bus_a.out_valid}, {7'd0, v});
    check({tag, " id"}, {5'd0, bus_a.out_id}, {5'd0, id});
    check({tag, " overflow"}, {7'd0, ovf_a}, {7'd0, o});
  endtask

  task automatic check_b(input string tag, input logic [7:0] p, input logic v,
                         input logic [2:0] id, input logic o);
    check({tag, " pending"}, pend_b, p);
    check({tag, " valid"}, {7'd0, bus_b.out_valid}, {7'd0, v});
    check({tag, " id"}, {5'd0, bus_b.out_id}, {5'd0, id});
    check({tag, " overflow"}, {7'd0, ovf_b}, {7'd0, o});
  endtask

  initial begin
    // priority: bits 6 and 2 together, consumer always ready
    vecs.push_back('{8'h44, 8'hFF, 1'b0, 1'b1, 8'h44, 1'b0, 3'd5, 1'b0});
    vecs.push_back('{8'h00, 8'hFF, 1'b0, 1'b1, 8'h44, 1'b1, 3'd6, 1'b0});
    vecs.push_back('{8'h00, 8'hFF, 1'b0, 1'b1, 8'h04, 1'b0, 3'd6, 1'b0});
    vecs.push_back('{8'h00, 8'hFF, 1'b0, 1'b1, 8'h04, 1'b1, 3'd2, 1'b0});
    vecs.push_back('{8'h00, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0, 3'd2, 1'b0});
    vecs.push_back('{8'h00, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0, 3'd2, 1'b0});
    // masking: bit 7 hidden, then unmasked while bit 0 is presented
    vecs.push_back('{8'h81, 8'h7F, 1'b0, 1'b0, 8'h81, 1'b0, 3'd2, 1'b0});
    vecs.push_back('{8'h00, 8'h7F, 1'b0, 1'b0, 8'h81, 1'b1, 3'd0, 1'b0});
    vecs.push_back('{8'h00, 8'hFF, 1'b0, 1'b0, 8'h81, 1'b1, 3'd0, 1'b0});
    vecs.push_back('{8'h00, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 3'd0, 1'b0});
    vecs.push_back('{8'h00, 8'hFF, 1'b0, 1'b0, 8'h80, 1'b1, 3'd7, 1'b0});
    vecs.push_back('{8'h00, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0, 3'd7, 1'b0});
    // set in the accept cycle, then overflow on a pending unaccepted bit
    vecs.push_back('{8'h08, 8'hFF, 1'b0, 1'b0, 8'h08, 1'b0, 3'd7, 1'b0});
    vecs.push_back('{8'h00, 8'hFF, 1'b0, 1'b0, 8'h08, 1'b1, 3'd3, 1'b0});
    vecs.push_back('{8'h00, 8'hFF, 1'b0, 1'b0, 8'h08, 1'b1, 3'd3, 1'b0});
    vecs.push_back('{8'h08, 8'hFF, 1'b0, 1'b1, 8'h08, 1'b0, 3'd3, 1'b0});
    vecs.push_back('{8'h00, 8'hFF, 1'b0, 1'b0, 8'h08, 1'b1, 3'd3, 1'b0});
    vecs.push_back('{8'h08, 8'hFF, 1'b0, 1'b0, 8'h08, 1'b1, 3'd3, 1'b1});
    vecs.push_back('{8'h00, 8'hFF, 1'b0, 1'b0, 8'h08, 1'b1, 3'd3, 1'b0});
    vecs.push_back('{8'h00, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0, 3'd3, 1'b0});
    // flush while presenting, with a simultaneous set that must be dropped
    vecs.push_back('{8'h0F, 8'hFF, 1'b0, 1'b0, 8'h0F, 1'b0, 3'd3, 1'b0});
    vecs.push_back('{8'h00, 8'hFF, 1'b0, 1'b0, 8'h0F, 1'b1, 3'd3, 1'b0});
    vecs.push_back('{8'h10, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 3'd3, 1'b0});
    vecs.push_back('{8'h00, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 3'd3, 1'b0});

    rst_a = 1'b1; req_a = 8'h00; mask_a = 8'hFF; clr_a = 1'b0; bus_a.out_ready = 1'b0;
    rst_b = 1'b1; req_b = 8'h00; mask_b = 8'hFF; clr_b = 1'b0; bus_b.out_ready = 1'b0;
    tick();
    tick();
    check_a("reset", 8'h00, 1'b0, 3'd0, 1'b0);
    rst_a = 1'b0;
    tick();
    check_a("post-reset", 8'h00, 1'b0, 3'd0, 1'b0);

    // single edge on bit 5, held unaccepted for ten cycles
    req_a = 8'h20;
    tick();
    check_a("edge5 k", 8'h20, 1'b0, 3'd0, 1'b0);
    req_a = 8'h00;
    tick();
    check_a("edge5 k+1", 8'h20, 1'b1, 3'd5, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_a($sformatf("edge5 hold%0d", i), 8'h20, 1'b1, 3'd5, 1'b0);
    end
    bus_a.out_ready = 1'b1;
    tick();
    check_a("edge5 accept", 8'h00, 1'b0, 3'd5, 1'b0);
    bus_a.out_ready = 1'b0;

    foreach (vecs[i]) begin
      req_a = vecs[i].req;
      mask_a = vecs[i].msk;
      clr_a = vecs[i].flush;
      bus_a.out_ready = vecs[i].rdy;
      tick();
      check_a($sformatf("vec%0d", i), vecs[i].exp_pend, vecs[i].exp_valid,
              vecs[i].exp_id, vecs[i].exp_ovf);
    end
    clr_a = 1'b0;
    mask_a = 8'hFF;
    bus_a.out_ready = 1'b0;

    // reset while presenting abandons the ID
    req_a = 8'h40;
    tick();
    req_a = 8'h00;
    tick();
    check_a("pre-rst present", 8'h40, 1'b1, 3'd6, 1'b0);
    rst_a = 1'b1;
    tick();
    check_a("mid-rst", 8'h00, 1'b0, 3'd0, 1'b0);
    rst_a = 1'b0;
    tick();
    check_a("after-rst", 8'h00, 1'b0, 3'd0, 1'b0);

    // level-mode instance: bit 1 high through reset release is not an edge
    req_b = 8'h02;
    tick();
    tick();
    rst_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_b($sformatf("lvl rel%0d", i), 8'h00, 1'b0, 3'd0, 1'b0);
    end
    // bit 0 held high re-pends on every accept and is granted every second cycle
    req_b = 8'h03;
    bus_b.out_ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check_b($sformatf("lvl c%0d", c), 8'h01, (c % 2 == 0), 3'd0, (c % 2 == 0));
    end
    req_b = 8'h02;
    tick();
    check_b("lvl drop", 8'h00, 1'b0, 3'd0, 1'b0);
    tick();
    check_b("lvl idle", 8'h00, 1'b0, 3'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
